audio_out_fifo: RTL
===================

AUDIO_OUT_FIFO -- requirements
Module: audio_out_fifo

Interface
REQ-001 SHALL have parameter TICKS_PER_SAMPLE, default 680, meaning clk cycles per stereo frame (30 MHz / 44.1 kHz).
REQ-002 SHALL have parameter DEPTH, default 64, meaning FIFO capacity in stereo frames; must be a power of two.
REQ-003 SHALL have parameter START_LEVEL, default 40, meaning the frame count that starts playback.
REQ-004 SHALL have parameter LOW_LEVEL, default 4, meaning the nearly_empty threshold in frames.
REQ-005 SHALL have port clk, input, 1, sole clock.
REQ-006 SHALL have port resetn, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port wr_left, input, 1, one-cycle pulse: CPU store of the left sample.
REQ-008 SHALL have port wr_right, input, 1, one-cycle pulse: CPU store of the right sample.
REQ-009 SHALL have port wr_data, input, 32, store data; bits [15:0] are the signed sample.
REQ-010 SHALL have port level, output, $clog2(DEPTH)+1, current frame count.
REQ-011 SHALL have port nearly_empty, output, 1, high when level < LOW_LEVEL.
REQ-012 SHALL have port full, output, 1, high when level == DEPTH.
REQ-013 SHALL have port playing, output, 1, high while in PLAY state.
REQ-014 SHALL have port underrun, output, 1, sticky flag.
REQ-015 SHALL have port overflow, output, 1, sticky flag.
REQ-016 SHALL have port pcm_left, output, 16, left sample of the current output frame.
REQ-017 SHALL have port pcm_right, output, 16, right sample of the current output frame.
REQ-018 SHALL have port pcm_strobe, output, 1, one-cycle pulse when pcm_left/pcm_right update.

Function
REQ-019 SHALL latch wr_data[15:0] into a left holding register on wr_left.
REQ-020 SHALL, on wr_right, push the frame {holding left, wr_data[15:0]}; a right without a preceding left reuses the last held left.
REQ-021 SHALL, when full, drop a push, leave contents unchanged, and set overflow.
REQ-022 SHALL, when wr_left and wr_right occur in the same cycle, use wr_data as both the new left and the right sample of the pushed frame.
REQ-023 SHALL implement a two-state FSM: FILL (reset state) and PLAY.
REQ-024 SHALL transition FILL -> PLAY on the cycle after level >= START_LEVEL; the tick counter restarts at 0 on entry.
REQ-025 SHALL, in PLAY only, run a tick counter 0..TICKS_PER_SAMPLE-1 that wraps to 0; the tick occurs when the counter equals TICKS_PER_SAMPLE-1.
REQ-026 SHALL, on a tick with level > 0, pop one frame and register it onto pcm_left/pcm_right with pcm_strobe high on the same edge.
REQ-027 SHALL, on a tick with level == 0, output 0/0 with pcm_strobe high, set underrun, and return to FILL.
REQ-028 SHALL, on a push and pop in the same cycle, leave level unchanged and keep data order intact (first word fall-through not required).
REQ-029 SHALL wrap read/write pointers modulo DEPTH; level is derived from pointers with one extra MSB.
REQ-030 SHALL register nearly_empty and full, one cycle behind level.
REQ-031 SHALL hold pcm_left/pcm_right between strobes and never change them in FILL except at reset.

Reset
REQ-032 SHALL, on resetn low, immediately clear pointers, level, holding register, tick counter, pcm_left, pcm_right, pcm_strobe, playing, underrun and overflow; set nearly_empty=1 and full=0; and set the FSM to FILL, including mid-frame or mid-push.
REQ-033 SHALL NOT reset the FIFO storage array; it is a RAM-inferable memory.

Structure
REQ-034 SHALL place TICKS_PER_SAMPLE, the default depth and threshold constants, and the audio_frame_t typedef (two signed 16-bit fields) in a shared package, audio_pkg.
REQ-035 SHALL use one sub-module, frame_fifo (DEPTH x 32 storage, pointers, level); the FSM, tick counter and output registers stay in audio_out_fifo.

Verification
REQ-036 SHALL test: 39 frames pushed -> playing stays 0; 40th push -> playing=1 one cycle later, first pcm_strobe 680 cycles after entry.
REQ-037 SHALL test: frames (0x1111,0x2222), (0x3333,0x4444) -> strobes output in order, 680 cycles apart.
REQ-038 SHALL test: 64 frames pushed then one more -> full=1, overflow=1, level=64, the 65th frame is never output.
REQ-039 SHALL test: playback to empty -> next tick outputs 0/0, underrun=1, FSM back in FILL, level=0.
REQ-040 SHALL test: push on the tick cycle with level=3 -> level stays 3 and nearly_empty=1.
REQ-041 SHALL test: resetn low 100 cycles into a frame -> all outputs at reset values asynchronously; after release, 40 pushes restart playback.

Source files
------------

// File: rtl/audio_pkg.sv
`timescale 1ns / 1ps
// audio_pkg
// Shared constants and types for the audio output path.
//   AUDIO_TICKS_PER_SAMPLE : clk cycles per stereo frame (30 MHz / 44.1 kHz)
//   AUDIO_DEPTH            : default FIFO capacity in stereo frames
//   AUDIO_START_LEVEL      : default frame count that starts playback
//   AUDIO_LOW_LEVEL        : default nearly_empty threshold in frames
//   audio_frame_t          : one stereo frame, left in the upper half
//   play_state_t           : playback FSM states
package audio_pkg;

    localparam int AUDIO_TICKS_PER_SAMPLE = 680;
    localparam int AUDIO_DEPTH            = 64;
    localparam int AUDIO_START_LEVEL      = 40;
    localparam int AUDIO_LOW_LEVEL        = 4;

    typedef struct packed {
        logic signed [15:0] left;
        logic signed [15:0] right;
    } audio_frame_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PLAY = 1'b1
    } play_state_t;

endpackage

// File: rtl/audio_out_fifo_frame_fifo.sv
`timescale 1ns / 1ps
// frame_fifo
// DEPTH x 32-bit stereo frame store with read/write pointers and level.
// The caller never pushes when full and never pops when empty.
//   clk          : clock
//   resetn       : asynchronous active-low reset (pointers only)
//   i_push       : write i_push_frame at the write pointer
//   i_push_frame : frame to store
//   i_pop        : advance the read pointer
//   o_head_frame : frame at the read pointer (oldest stored frame)
//   o_level      : number of stored frames, 0..DEPTH
module frame_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = AUDIO_DEPTH
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   i_push,
    input  audio_frame_t           i_push_frame,
    input  logic                   i_pop,
    output audio_frame_t           o_head_frame,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

    // Storage has no reset so it maps onto RAM; stale contents are never
    // visible because the pointers are cleared.
    audio_frame_t r_mem [DEPTH];

    // One extra MSB on each pointer distinguishes full from empty.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_INC;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_INC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_frame;
        end
    end

    // The head is captured by the output registers in the parent on the
    // pop edge, so that register acts as the RAM read register.
    assign o_head_frame = r_mem[r_rd_ptr[AW-1:0]];
    assign o_level      = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/audio_out_fifo.sv
`timescale 1ns / 1ps
// audio_out_fifo
// CPU-fed stereo sample FIFO with a fixed-rate playback side. Samples are
// buffered until START_LEVEL frames are held, then one frame is presented
// every TICKS_PER_SAMPLE cycles. Running dry emits a silent frame, flags
// underrun and returns to buffering.
//   clk          : sole clock
//   resetn       : asynchronous active-low reset
//   wr_left      : pulse, latch wr_data[15:0] as the held left sample
//   wr_right     : pulse, push {held left, wr_data[15:0]} as one frame
//   wr_data      : store data, [15:0] is the signed sample
//   level        : current frame count
//   nearly_empty : registered, level < LOW_LEVEL
//   full         : registered, level == DEPTH
//   playing      : high while in PLAY
//   underrun     : sticky, a tick found the FIFO empty
//   overflow     : sticky, a push was dropped because the FIFO was full
//   pcm_left     : left sample of the current output frame
//   pcm_right    : right sample of the current output frame
//   pcm_strobe   : one-cycle pulse when pcm_left/pcm_right update
module audio_out_fifo
    import audio_pkg::*;
#(
    parameter int TICKS_PER_SAMPLE = AUDIO_TICKS_PER_SAMPLE,
    parameter int DEPTH            = AUDIO_DEPTH,
    parameter int START_LEVEL      = AUDIO_START_LEVEL,
    parameter int LOW_LEVEL        = AUDIO_LOW_LEVEL
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_left,
    input  logic                   wr_right,
    input  logic [31:0]            wr_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   nearly_empty,
    output logic                   full,
    output logic                   playing,
    output logic                   underrun,
    output logic                   overflow,
    output logic [15:0]            pcm_left,
    output logic [15:0]            pcm_right,
    output logic                   pcm_strobe
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = (TICKS_PER_SAMPLE > 1) ? $clog2(TICKS_PER_SAMPLE) : 1;

    localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_SAMPLE - 1);
    localparam logic [CW-1:0] CNT_INC   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LVL_DEPTH = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_START = LW'(START_LEVEL);
    localparam logic [LW-1:0] LVL_LOW   = LW'(LOW_LEVEL);

    play_state_t   r_state;
    logic [CW-1:0] r_tick_cnt;
    logic [15:0]   r_hold_left;
    logic [15:0]   r_pcm_left;
    logic [15:0]   r_pcm_right;
    logic          r_pcm_strobe;
    logic          r_underrun;
    logic          r_overflow;
    logic          r_nearly_empty;
    logic          r_full;

    logic [LW-1:0] w_level;
    logic          w_full_now;
    logic          w_empty_now;
    logic          w_tick;
    logic          w_pop;
    logic          w_push;
    logic          w_push_drop;
    logic [15:0]   w_left_sel;
    audio_frame_t  w_push_frame;
    audio_frame_t  w_head_frame;
    logic          w_unused_data_hi;

    // Upper store bits carry no audio.
    assign w_unused_data_hi = ^wr_data[31:16];

    assign w_full_now  = (w_level == LVL_DEPTH);
    assign w_empty_now = (w_level == '0);
    assign w_tick      = (r_state == ST_PLAY) && (r_tick_cnt == TICK_LAST);
    assign w_pop       = w_tick && !w_empty_now;

    // A simultaneous left store supplies the left half of this very frame.
    assign w_left_sel   = wr_left ? wr_data[15:0] : r_hold_left;
    assign w_push_frame = {w_left_sel, wr_data[15:0]};
    assign w_push       = wr_right && !w_full_now;
    assign w_push_drop  = wr_right && w_full_now;

    frame_fifo #(
        .DEPTH (DEPTH)
    ) u_frame_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .i_push       (w_push),
        .i_push_frame (w_push_frame),
        .i_pop        (w_pop),
        .o_head_frame (w_head_frame),
        .o_level      (w_level)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hold_left <= '0;
        end else if (wr_left) begin
            r_hold_left <= wr_data[15:0];
        end
    end

    // Playback FSM with the tick counter and registered PCM outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_FILL;
            r_tick_cnt   <= '0;
            r_pcm_left   <= '0;
            r_pcm_right  <= '0;
            r_pcm_strobe <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_pcm_strobe <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    // Held at zero so PLAY always starts a full frame period.
                    r_tick_cnt <= '0;
                    if (w_level >= LVL_START) begin
                        r_state <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (w_tick) begin
                        r_tick_cnt   <= '0;
                        r_pcm_strobe <= 1'b1;
                        if (w_empty_now) begin
                            r_pcm_left  <= '0;
                            r_pcm_right <= '0;
                            r_underrun  <= 1'b1;
                            r_state     <= ST_FILL;
                        end else begin
                            r_pcm_left  <= w_head_frame.left;
                            r_pcm_right <= w_head_frame.right;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + CNT_INC;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    // Status flags; nearly_empty/full deliberately lag level by one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overflow     <= 1'b0;
            r_nearly_empty <= 1'b1;
            r_full         <= 1'b0;
        end else begin
            if (w_push_drop) begin
                r_overflow <= 1'b1;
            end
            r_nearly_empty <= (w_level < LVL_LOW);
            r_full         <= w_full_now;
        end
    end

    assign level        = w_level;
    assign nearly_empty = r_nearly_empty;
    assign full         = r_full;
    assign playing      = (r_state == ST_PLAY);
    assign underrun     = r_underrun;
    assign overflow     = r_overflow;
    assign pcm_left     = r_pcm_left;
    assign pcm_right    = r_pcm_right;
    assign pcm_strobe   = r_pcm_strobe;

endmodule
